// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the multi-channel UART receive harness.
package sim_uart_pkg;

  // Width of one UART character (8N1 framing).
  localparam int DataBits = 8;

  // Per-channel receiver states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Number of system clocks per serial bit.
  function automatic int clk_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

  // True when v is a positive power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sim_uart_rx_chan.sv
// One UART receive channel: 2-FF synchroniser, 8N1 deserialiser FSM and a
// byte FIFO with a pop handshake toward the channel arbiter.
module sim_uart_rx_chan
  import sim_uart_pkg::*;
#(
  parameter int ClkPerBit = 8,
  parameter int FifoDepth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                active_i,
  input  logic                rx_i,
  input  logic                pop_i,
  output logic                empty_o,
  output logic [DataBits-1:0] data_o,
  output logic                frame_err_o,
  output logic                overflow_o
);

  localparam int CntW    = $clog2(ClkPerBit);
  localparam int BitCntW = $clog2(DataBits);
  localparam int AddrW   = $clog2(FifoDepth);

  localparam logic [CntW-1:0]    BitLast  = CntW'(ClkPerBit - 1);
  localparam logic [CntW-1:0]    HalfLast = CntW'((ClkPerBit / 2) - 1);
  localparam logic [BitCntW-1:0] DataLast = BitCntW'(DataBits - 1);

  // Synchroniser and edge detector
  logic [1:0] r_sync;
  logic       r_rx_prev;
  logic       w_rx;
  logic       w_fall;

  // Receiver state
  rx_state_e           r_state;
  logic [CntW-1:0]     r_baud_cnt;
  logic [BitCntW-1:0]  r_bit_cnt;
  logic [DataBits-1:0] r_shift;
  logic                r_push;
  logic [DataBits-1:0] r_push_data;
  logic                r_frame_err;

  // FIFO state
  logic [DataBits-1:0] r_mem [FifoDepth];
  logic [AddrW:0]      r_wr_ptr;
  logic [AddrW:0]      r_rd_ptr;
  logic                r_ovf;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_wr_en;
  logic                w_drop;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_prev & ~w_rx;

  // Bring the asynchronous line into the clock domain; preset to idle-high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx_i};
      r_rx_prev <= r_sync[1];
    end
  end

  // Deserialiser FSM: mid-bit sampling of start, data and stop bits.
  // The falling-edge cycle counts as the first cycle of the start bit, so
  // the START sample lands half a bit after the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      if (!active_i) begin
        r_state    <= IDLE;
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_fall) begin
              r_state    <= START;
              r_baud_cnt <= CntW'(1);
              r_bit_cnt  <= '0;
            end
          end
          START: begin
            if (r_baud_cnt == HalfLast) begin
              r_baud_cnt <= '0;
              r_state    <= w_rx ? IDLE : DATA;
            end else begin
              r_baud_cnt <= r_baud_cnt + CntW'(1);
            end
          end
          DATA: begin
            if (r_baud_cnt == BitLast) begin
              r_baud_cnt <= '0;
              r_shift    <= {w_rx, r_shift[DataBits-1:1]};
              if (r_bit_cnt == DataLast) begin
                r_state <= STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BitCntW'(1);
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + CntW'(1);
            end
          end
          STOP: begin
            if (r_baud_cnt == BitLast) begin
              r_baud_cnt <= '0;
              if (w_rx) begin
                r_push      <= 1'b1;
                r_push_data <= r_shift;
                r_state     <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= BREAK;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + CntW'(1);
            end
          end
          BREAK: begin
            if (w_rx) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                   (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
  assign w_pop   = pop_i & ~w_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr_en = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;

  // FIFO storage write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr[AddrW-1:0]] <= r_push_data;
    end
  end

  // FIFO pointers (extra MSB separates full from empty) and drop event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= w_drop;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AddrW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AddrW+1)'(1);
      end
    end
  end

  assign empty_o     = w_empty;
  assign data_o      = r_mem[r_rd_ptr[AddrW-1:0]];
  assign frame_err_o = r_frame_err;
  assign overflow_o  = r_ovf;

endmodule

// File: rtl/sim_uart_rx_mux.sv
// Multi-channel UART receive harness: one receiver per console line, merged
// by a round-robin arbiter into a single registered, tagged byte stream.
module sim_uart_rx_mux
  import sim_uart_pkg::*;
#(
  parameter int NumChannels    = 4,
  parameter int ClockFrequency = 125_000_000,
  parameter int BaudRate       = 15_625_000,
  parameter int FifoDepth      = 8,
  localparam int ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   active_i,
  input  logic [NumChannels-1:0] rx_i,
  output logic                   byte_valid_o,
  input  logic                   byte_ready_i,
  output logic [7:0]             byte_data_o,
  output logic [ChanW-1:0]       byte_chan_o,
  output logic [NumChannels-1:0] frame_err_o,
  output logic [NumChannels-1:0] overflow_o,
  input  logic [NumChannels-1:0] overflow_clr_i
);

  localparam int ClkPerBit = clk_per_bit(ClockFrequency, BaudRate);

  if (ClkPerBit < 4) begin : g_bad_baud
    $error("sim_uart_rx_mux: ClockFrequency/BaudRate must be at least 4");
  end
  if (!is_pow2(FifoDepth) || (FifoDepth < 2)) begin : g_bad_depth
    $error("sim_uart_rx_mux: FifoDepth must be a power of two >= 2");
  end
  if (NumChannels < 1) begin : g_bad_chan
    $error("sim_uart_rx_mux: NumChannels must be >= 1");
  end

  // Channel-side signals
  logic [NumChannels-1:0] w_empty;
  logic [NumChannels-1:0] w_pop;
  logic [NumChannels-1:0] w_frame_err;
  logic [NumChannels-1:0] w_ovf_evt;
  logic [DataBits-1:0]    w_data [NumChannels];

  // Arbiter and output stage
  logic                   w_load;
  logic                   w_grant_vld;
  logic [ChanW-1:0]       w_grant;
  logic [ChanW-1:0]       w_idx;
  logic                   w_hit;
  logic [ChanW-1:0]       r_rr_ptr;
  logic                   r_valid;
  logic [DataBits-1:0]    r_data;
  logic [ChanW-1:0]       r_chan;
  logic [NumChannels-1:0] r_overflow;

  // Channel index base+off modulo NumChannels (off < NumChannels).
  function automatic logic [ChanW-1:0] wrap_add(input logic [ChanW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= NumChannels) ? ChanW'(sum - NumChannels) : ChanW'(sum);
  endfunction

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    sim_uart_rx_chan #(
      .ClkPerBit (ClkPerBit),
      .FifoDepth (FifoDepth)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .active_i    (active_i),
      .rx_i        (rx_i[c]),
      .pop_i       (w_pop[c]),
      .empty_o     (w_empty[c]),
      .data_o      (w_data[c]),
      .frame_err_o (w_frame_err[c]),
      .overflow_o  (w_ovf_evt[c])
    );
  end

  // The output register takes a new byte when it is empty or being consumed.
  assign w_load = ~r_valid | byte_ready_i;

  // Round-robin search: first non-empty FIFO at or after the pointer.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    w_hit       = 1'b0;
    for (int i = 0; i < NumChannels; i++) begin
      w_idx       = wrap_add(r_rr_ptr, i);
      w_hit       = ~w_grant_vld & ~w_empty[w_idx];
      w_grant     = w_hit ? w_idx : w_grant;
      w_grant_vld = w_grant_vld | w_hit;
    end
  end

  // Pop strobe toward the granted channel.
  always_comb begin
    w_pop = '0;
    if (w_load && w_grant_vld) begin
      w_pop[w_grant] = 1'b1;
    end else begin
      w_pop = '0;
    end
  end

  // Output register: holds data/channel stable until the sink takes them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_chan   <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      if (w_grant_vld) begin
        r_valid  <= 1'b1;
        r_data   <= w_data[w_grant];
        r_chan   <= w_grant;
        r_rr_ptr <= wrap_add(w_grant, 1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow flags; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= '0;
    end else begin
      r_overflow <= (r_overflow & ~overflow_clr_i) | w_ovf_evt;
    end
  end

  assign byte_valid_o = r_valid;
  assign byte_data_o  = r_data;
  assign byte_chan_o  = r_chan;
  assign frame_err_o  = w_frame_err;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_sim_uart_rx_mux.sv
// Directed bench for sim_uart_rx_mux at ClkPerBit = 8 (default parameters).
module tb_sim_uart_rx_mux;

  localparam int NC  = 4;
  localparam int CPB = 8;

  logic          clk;
  logic          rst_n;
  logic          active;
  logic [NC-1:0] rx;
  logic          byte_valid;
  logic          byte_ready;
  logic [7:0]    byte_data;
  logic [1:0]    byte_chan;
  logic [NC-1:0] frame_err;
  logic [NC-1:0] overflow;
  logic [NC-1:0] ovf_clr;

  int errors = 0;
  int checks = 0;
  int cycles;
  int err_cnt [NC];
  int err_base;

  logic [7:0] cap_data [$];
  logic [1:0] cap_chan [$];

  sim_uart_rx_mux dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .active_i       (active),
    .rx_i           (rx),
    .byte_valid_o   (byte_valid),
    .byte_ready_i   (byte_ready),
    .byte_data_o    (byte_data),
    .byte_chan_o    (byte_chan),
    .frame_err_o    (frame_err),
    .overflow_o     (overflow),
    .overflow_clr_i (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int c = 0; c < NC; c++) err_cnt[c] = 0;
  end

  // Capture handshakes and count frame-error cycles, sampled mid-low-phase.
  always @(negedge clk) begin
    #1;
    if (byte_valid && byte_ready) begin
      cap_data.push_back(byte_data);
      cap_chan.push_back(byte_chan);
    end
    for (int c = 0; c < NC; c++) begin
      if (frame_err[c]) err_cnt[c] = err_cnt[c] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic [1:0] ch);
    logic [7:0] gd;
    logic [1:0] gc;
    checks++;
    assert (cap_data.size() > 0) else begin
      errors++;
      $error("FAIL %s_present: got no beat expected data %0h chan %0d", tag, d, ch);
    end
    if (cap_data.size() > 0) begin
      gd = cap_data.pop_front();
      gc = cap_chan.pop_front();
      chk({tag, "_data"}, {24'h0, gd}, {24'h0, d});
      chk({tag, "_chan"}, {30'h0, gc}, {30'h0, ch});
    end
  endtask

  // Drive one 8N1 frame on every channel in mask; optionally drop active_i
  // when bit index off_bit (0 = start bit) begins.
  task automatic send_frame(input logic [NC-1:0] mask,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3,
                            input logic stop_bit, input int off_bit);
    logic [7:0] d [NC];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < NC; c++) begin
        if (mask[c]) begin
          if (b == 0)      rx[c] = 1'b0;
          else if (b == 9) rx[c] = stop_bit;
          else             rx[c] = d[c][b-1];
        end
      end
      if (b == off_bit) active = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) rx[c] = 1'b1;
    end
    active = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    active     = 1'b1;
    rx         = '1;
    byte_ready = 1'b1;
    ovf_clr    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, byte_valid}, 32'h0);
    chk("rst_data", {24'h0, byte_data}, 32'h0);
    chk("rst_chan", {30'h0, byte_chan}, 32'h0);
    chk("rst_ferr", {28'h0, frame_err}, 32'h0);
    chk("rst_ovf", {28'h0, overflow}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Simultaneous bytes, pointer at 0: order 0,1,2,3
    send_frame(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_beat("rr0_a", 8'h11, 2'd0);
    expect_beat("rr0_b", 8'h22, 2'd1);
    expect_beat("rr0_c", 8'h33, 2'd2);
    expect_beat("rr0_d", 8'h44, 2'd3);

    // One byte on ch0 moves the pointer to 1, then the repeat gives 1,2,3,0
    send_frame(4'b0001, 8'h77, 8'h00, 8'h00, 8'h00, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_beat("ptr_set", 8'h77, 2'd0);
    send_frame(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_beat("rr1_a", 8'h22, 2'd1);
    expect_beat("rr1_b", 8'h33, 2'd2);
    expect_beat("rr1_c", 8'h44, 2'd3);
    expect_beat("rr1_d", 8'h11, 2'd0);
    chk("rr1_extra", cap_data.size(), 32'd0);

    // Latency of a single byte: 2 + 9.5*8 + 1 = 79 cycles, +/-1
    cycles = 0;
    fork
      send_frame(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1, -1);
      begin
        while (!byte_valid && cycles < 200) begin
          @(posedge clk);
          #1;
          cycles++;
        end
      end
    join
    checks++;
    assert (cycles >= 78 && cycles <= 80) else begin
      errors++;
      $error("FAIL a5_latency: got %0d cycles expected 78..80", cycles);
    end
    repeat (10) @(negedge clk);
    expect_beat("a5", 8'hA5, 2'd2);

    // Stop bit low on ch1: one-cycle frame error, no beat, then recovery
    err_base = err_cnt[1];
    send_frame(4'b0010, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0, -1);
    repeat (24) @(negedge clk);
    chk("ferr_pulse", err_cnt[1] - err_base, 32'd1);
    chk("ferr_nobeat", cap_data.size(), 32'd0);
    send_frame(4'b0010, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_beat("ferr_recover", 8'h5A, 2'd1);

    // Two-cycle glitch on ch3: no error, no byte
    err_base = err_cnt[3];
    rx[3] = 1'b0;
    repeat (2) @(negedge clk);
    rx[3] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_noerr", err_cnt[3] - err_base, 32'd0);
    chk("glitch_nobeat", cap_data.size(), 32'd0);

    // active_i dropped mid-frame on ch2: frame discarded, next frame fine
    send_frame(4'b0100, 8'h00, 8'h00, 8'h96, 8'h00, 1'b1, 3);
    repeat (20) @(negedge clk);
    chk("inactive_nobeat", cap_data.size(), 32'd0);
    send_frame(4'b0100, 8'h00, 8'h00, 8'hC3, 8'h00, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_beat("inactive_recover", 8'hC3, 2'd2);

    // Overflow: output register already holds a ch1 byte, then 9 bytes on
    // ch0 fill the 8-entry FIFO and the ninth is dropped.
    byte_ready = 1'b0;
    send_frame(4'b0010, 8'h00, 8'hE1, 8'h00, 8'h00, 1'b1, -1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      send_frame(4'b0001, 8'(8'h80 + i), 8'h00, 8'h00, 8'h00, 1'b1, -1);
    end
    repeat (8) @(negedge clk);
    chk("ovf_flag", {28'h0, overflow}, 32'h1);
    chk("ovf_hold_valid", {31'h0, byte_valid}, 32'h1);
    chk("ovf_hold_data", {24'h0, byte_data}, 32'hE1);
    chk("ovf_hold_chan", {30'h0, byte_chan}, 32'h1);
    byte_ready = 1'b1;
    repeat (20) @(negedge clk);
    expect_beat("ovf_head", 8'hE1, 2'd1);
    for (int i = 0; i < 8; i++) begin
      expect_beat($sformatf("ovf_drain%0d", i), 8'(8'h80 + i), 2'd0);
    end
    chk("ovf_ninth_lost", cap_data.size(), 32'd0);
    chk("ovf_sticky", {28'h0, overflow}, 32'h1);
    ovf_clr = 4'b0001;
    @(negedge clk);
    ovf_clr = 4'b0000;
    @(negedge clk);
    chk("ovf_cleared", {28'h0, overflow}, 32'h0);

    // Reset with a pending output byte and a frame in flight on ch1
    byte_ready = 1'b0;
    send_frame(4'b1000, 8'h00, 8'h00, 8'h00, 8'h99, 1'b1, -1);
    repeat (4) @(negedge clk);
    chk("prerst_valid", {31'h0, byte_valid}, 32'h1);
    rx[1] = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    rx    = '1;
    #1;
    chk("midrst_valid", {31'h0, byte_valid}, 32'h0);
    chk("midrst_data", {24'h0, byte_data}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    byte_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("postrst_empty", cap_data.size(), 32'd0);
    send_frame(4'b0010, 8'h00, 8'h6B, 8'h00, 8'h00, 1'b1, -1);
    repeat (20) @(negedge clk);
    expect_beat("postrst", 8'h6B, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
